oht_seq_ctrl: RTL and testbench

// - Sequencer and read-side controller for the online health test (OHT) block.
// - Generates the adc_en sample strobe, resets and warms up the OHT, and reacts to health failures:
//   - intermittent fail -> settle pause
//   - permanent fail -> sticky fault
// - Drains checked noise words from the OHT FIFO onto a valid/ready output port for the conditioner.

---
 rtl/oht_seq_ctrl_pkg.sv | 25 ++
 rtl/oht_seq_ctrl_adc_strobe_gen.sv | 25 ++
 rtl/oht_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_oht_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oht_seq_ctrl_pkg.sv
// Shared state type, word width and default timing constants for the OHT sequencer.
package oht_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET_OHT = 3'd1,
    WARMUP    = 3'd2,
    RUN       = 3'd3,
    RECAL     = 3'd4,
    DRAIN     = 3'd5,
    FAULT     = 3'd6
  } ctrl_state_t;

  localparam int SAMPLE_SIZE        = 256;
  localparam int DEF_RST_CYCLES     = 4;
  localparam int DEF_WARMUP_SAMPLES = 1024;
  localparam int DEF_SETTLE_CYCLES  = 64;
  localparam int DEF_RECAL_LIMIT    = 8;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/oht_seq_ctrl_adc_strobe_gen.sv
// Sample strobe divider: one-clk strobe every div+1 clks while run is high.
// Dropping run reloads the counter, so the first strobe after run rises comes div+1 clks later.
module oht_seq_ctrl_adc_strobe_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] div,
  output logic       strobe
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == 8'd0) begin
      cnt <= div;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign strobe = run && (cnt == 8'd0);

endmodule

// File: rtl/oht_seq_ctrl.sv
// OHT sequencer: start-up reset/warm-up, failure handling and the 1-entry read-side output register.
//   state     | meaning
//   IDLE      | stopped, clk_div tracked
//   RESET_OHT | oht_rst held for RST_CYCLES
//   WARMUP    | strobes discarded, then FIFO flushed
//   RUN       | strobes and read path active
//   RECAL     | strobes paused for SETTLE_CYCLES, read path active
//   DRAIN     | strobes stopped, FIFO emptied to the consumer
//   FAULT     | sticky permanent fault, left only via rst_n
module oht_seq_ctrl
  import oht_seq_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int WARMUP_SAMPLES = DEF_WARMUP_SAMPLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int RECAL_LIMIT    = DEF_RECAL_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [7:0]             clk_div,
  input  logic                   oht_inter_fail,
  input  logic                   oht_perm_fail,
  input  logic                   oht_empty,
  input  logic [SAMPLE_SIZE-1:0] oht_checked_noise,
  output logic                   adc_en,
  output logic                   oht_rst,
  output logic                   oht_deque,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SAMPLE_SIZE-1:0] out_data,
  output logic [2:0]             state,
  output logic [15:0]            inter_fail_cnt,
  output logic                   fault
);

  localparam int TMR_W  = cnt_width((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES);
  localparam int WARM_W = cnt_width(WARMUP_SAMPLES);
  localparam int RC_W   = cnt_width(RECAL_LIMIT);

  localparam logic [TMR_W-1:0]  RST_LOAD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [WARM_W-1:0] WARM_LOAD   = WARM_W'(WARMUP_SAMPLES);
  localparam logic [RC_W-1:0]   RC_LIMIT    = RC_W'(RECAL_LIMIT);

  ctrl_state_t            state_q, state_d;
  logic [TMR_W-1:0]       tmr_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   flush_q;
  logic [7:0]             div_q;
  logic                   pop_q;
  logic                   out_valid_q;
  logic [SAMPLE_SIZE-1:0] out_data_q;
  logic                   inter_prev_q;
  logic [15:0]            inter_cnt_q;
  logic [RC_W-1:0]        recal_q;

  logic            strobe_run;
  logic            read_phase;
  logic            hs;
  logic            inter_rise;
  logic            recal_entry;
  logic            go_fault;
  logic [RC_W-1:0] recal_next;

  assign strobe_run  = (state_q == WARMUP && !flush_q) || state_q == RUN;
  assign read_phase  = state_q == RUN || state_q == RECAL || state_q == DRAIN;
  assign hs          = out_valid_q && out_ready;
  assign inter_rise  = oht_inter_fail && !inter_prev_q;
  assign recal_entry = (state_q == RUN) && inter_rise;
  assign go_fault    = (state_q != IDLE) && oht_perm_fail;
  // A handshake in the same clk as a recal entry clears first, then counts the entry.
  assign recal_next  = (hs ? '0 : recal_q) + RC_W'(recal_entry);

  oht_seq_ctrl_adc_strobe_gen u_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (strobe_run),
    .div    (div_q),
    .strobe (adc_en)
  );

  // One pop in flight at a time; the FIFO presents the popped word on the following clk.
  always_comb begin
    oht_deque = 1'b0;
    if (!go_fault && !pop_q && !oht_empty) begin
      if (read_phase && (!out_valid_q || out_ready)) begin
        oht_deque = 1'b1;
      end else if (state_q == WARMUP && flush_q) begin
        oht_deque = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable) state_d = RESET_OHT;
      RESET_OHT: if (tmr_q == '0) state_d = WARMUP;
      WARMUP:    if (flush_q && oht_empty && !pop_q) state_d = RUN;
      RUN: begin
        if (recal_entry) begin
          state_d = (recal_next >= RC_LIMIT) ? FAULT : RECAL;
        end else if (!enable) begin
          state_d = DRAIN;
        end
      end
      RECAL:     if (tmr_q == '0) state_d = RUN;
      DRAIN:     if (oht_empty && !out_valid_q && !pop_q) state_d = IDLE;
      FAULT:     state_d = FAULT;
      default:   state_d = IDLE;
    endcase
    if (go_fault) state_d = FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if (state_q == IDLE && state_d == RESET_OHT) begin
      tmr_q <= RST_LOAD;
    end else if (state_q == RUN && state_d == RECAL) begin
      tmr_q <= SETTLE_LOAD;
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q  <= WARM_LOAD;
      flush_q <= 1'b0;
    end else if (state_q != WARMUP) begin
      warm_q  <= WARM_LOAD;
      flush_q <= 1'b0;
    end else if (adc_en) begin
      warm_q <= warm_q - WARM_W'(1);
      if (warm_q == WARM_W'(1)) flush_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      pop_q        <= 1'b0;
      inter_prev_q <= 1'b0;
      inter_cnt_q  <= '0;
      recal_q      <= '0;
    end else begin
      if (state_q == IDLE) div_q <= clk_div;
      pop_q        <= oht_deque;
      inter_prev_q <= oht_inter_fail;
      if (recal_entry && inter_cnt_q != 16'hFFFF) inter_cnt_q <= inter_cnt_q + 16'd1;
      recal_q <= (state_q == IDLE) ? '0 : recal_next;
    end
  end

  // Words popped while flushing in WARMUP are dropped; FAULT forces the register empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (state_d == FAULT) begin
      out_valid_q <= 1'b0;
    end else if (pop_q && state_q != WARMUP) begin
      out_valid_q <= 1'b1;
      out_data_q  <= oht_checked_noise;
    end else if (hs) begin
      out_valid_q <= 1'b0;
    end
  end

  assign oht_rst        = (state_q == RESET_OHT);
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign state          = state_q;
  assign inter_fail_cnt = inter_cnt_q;
  assign fault          = (state_q == FAULT);

endmodule

// File: tb/tb_oht_seq_ctrl.sv
// Bench for oht_seq_ctrl: registered-read FIFO model, in-order scoreboard and table-driven start/recal cases.
module tb_oht_seq_ctrl;
  import oht_seq_ctrl_pkg::*;

  localparam int S_IDLE = 0, S_WARMUP = 2, S_RUN = 3, S_RECAL = 4, S_DRAIN = 5, S_FAULT = 6;

  typedef struct {
    logic [7:0] div;
    int         pre;
    int         rst_cyc;
    int         strobes;
    int         period;
  } start_vec_t;

  typedef struct {
    int pulses;
    int hs_after;
    int exp_state;
    int exp_cnt;
  } recal_vec_t;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic oht_inter_fail = 1'b0, oht_perm_fail = 1'b0, oht_empty = 1'b1;
  logic [7:0] clk_div = 8'd0;
  logic [SAMPLE_SIZE-1:0] oht_checked_noise = '0;
  logic adc_en, oht_rst, oht_deque, out_valid, fault;
  logic [SAMPLE_SIZE-1:0] out_data;
  logic [2:0] state;
  logic [15:0] inter_fail_cnt;

  logic [SAMPLE_SIZE-1:0] fifo[$];
  logic [SAMPLE_SIZE-1:0] exp_q[$];
  logic [SAMPLE_SIZE-1:0] hold;
  logic stall_prev = 1'b0, mon_on = 1'b0, underflow = 1'b0;
  int total = 0, bad = 0, hs_count = 0;

  oht_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clk_div(clk_div),
    .oht_inter_fail(oht_inter_fail), .oht_perm_fail(oht_perm_fail),
    .oht_empty(oht_empty), .oht_checked_noise(oht_checked_noise),
    .adc_en(adc_en), .oht_rst(oht_rst), .oht_deque(oht_deque),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .state(state), .inter_fail_cnt(inter_fail_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [SAMPLE_SIZE-1:0] act,
                       input logic [SAMPLE_SIZE-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // FIFO with registered read data: the popped word appears the clk after the pop.
  always @(posedge clk) begin
    if (oht_deque) begin
      if (fifo.size() > 0) oht_checked_noise <= fifo.pop_front();
      else underflow <= 1'b1;
    end
  end

  always @(negedge clk) oht_empty <= (fifo.size() == 0);

  // Every handshake must deliver the oldest expected word; a stalled word must hold.
  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk_w("stall_data", out_data, hold);
      end
      if (out_valid && out_ready) begin
        hs_count <= hs_count + 1;
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else chk_w("hs_data", out_data, exp_q.pop_front());
      end
      stall_prev <= out_valid && !out_ready;
      hold       <= out_data;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input bit expect_it, output logic [SAMPLE_SIZE-1:0] w);
    for (int i = 0; i < SAMPLE_SIZE / 32; i++) w[i*32 +: 32] = $urandom;
    fifo.push_back(w);
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), S_IDLE);
    chk({tag, "_adc_en"}, 32'(adc_en), 0);
    chk({tag, "_oht_rst"}, 32'(oht_rst), 0);
    chk({tag, "_deque"}, 32'(oht_deque), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk_w({tag, "_data"}, out_data, '0);
    chk({tag, "_cnt"}, 32'(inter_fail_cnt), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0; enable = 1'b0; oht_inter_fail = 1'b0; oht_perm_fail = 1'b0; out_ready = 1'b0;
    fifo.delete();
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic bring_up(input start_vec_t v);
    int rst_seen = 0, strobes = 0, since = 0, gap_bad = 0, valid_warm = 0, n = 0;
    logic [SAMPLE_SIZE-1:0] w;
    for (int i = 0; i < v.pre; i++) push_word(1'b0, w);
    clk_div = v.div;
    enable  = 1'b1;
    while (n < v.strobes * (int'(v.div) + 1) + 200) begin
      tick(1);
      n++;
      if (state == 3'(S_RUN)) break;
      if (oht_rst) rst_seen++;
      if (out_valid) valid_warm++;
      if (state == 3'(S_WARMUP)) begin
        since++;
        if (adc_en) begin
          strobes++;
          if (since != v.period) gap_bad++;
          since = 0;
        end
      end
    end
    chk("start_reach_run", 32'(state), S_RUN);
    chk("start_rst_cycles", rst_seen, v.rst_cyc);
    chk("start_strobes", strobes, v.strobes);
    chk("start_period_errs", gap_bad, 0);
    chk("start_no_valid", valid_warm, 0);
    chk("start_flushed", fifo.size(), 0);
    mon_on = 1'b1;
  endtask

  task automatic run_recal(input recal_vec_t v);
    int n, hs0;
    logic [SAMPLE_SIZE-1:0] w;
    for (int p = 1; p <= v.pulses; p++) begin
      oht_inter_fail = 1'b1;
      tick(1);
      oht_inter_fail = 1'b0;
      tick(1);
      n = 0;
      while (state == 3'(S_RECAL) && n < 200) begin tick(1); n++; end
      if (p == v.hs_after) begin
        hs0 = hs_count;
        push_word(1'b1, w);
        out_ready = 1'b1;
        n = 0;
        while (hs_count == hs0 && n < 50) begin tick(1); n++; end
        chk("recal_handshake", hs_count - hs0, 1);
        out_ready = 1'b0;
      end
    end
    chk("recal_state", 32'(state), v.exp_state);
    chk("recal_cnt", 32'(inter_fail_cnt), v.exp_cnt);
    chk("recal_fault", 32'(fault), (v.exp_state == S_FAULT) ? 1 : 0);
  endtask

  start_vec_t start_tab[3];
  recal_vec_t recal_tab[4];

  initial begin
    int n, zeros, hs0, pushed, since, gap_bad;
    bit have;
    logic [SAMPLE_SIZE-1:0] w, w0;

    start_tab[0] = '{div: 8'd3, pre: 2, rst_cyc: 4, strobes: 1024, period: 4};
    start_tab[1] = '{div: 8'd0, pre: 0, rst_cyc: 4, strobes: 1024, period: 1};
    start_tab[2] = '{div: 8'd2, pre: 1, rst_cyc: 4, strobes: 1024, period: 3};
    recal_tab[0] = '{pulses: 1, hs_after: 0, exp_state: S_RUN,   exp_cnt: 1};
    recal_tab[1] = '{pulses: 7, hs_after: 0, exp_state: S_RUN,   exp_cnt: 7};
    recal_tab[2] = '{pulses: 8, hs_after: 0, exp_state: S_FAULT, exp_cnt: 8};
    recal_tab[3] = '{pulses: 8, hs_after: 7, exp_state: S_RUN,   exp_cnt: 8};

    #2;
    check_reset_vals("por");

    for (int r = 0; r < 3; r++) begin
      do_reset();
      bring_up(start_tab[r]);
    end

    for (int r = 0; r < 4; r++) begin
      do_reset();
      bring_up(start_tab[1]);
      run_recal(recal_tab[r]);
    end

    // Settle pause length after one intermittent fail.
    do_reset();
    bring_up(start_tab[1]);
    oht_inter_fail = 1'b1;
    tick(1);
    oht_inter_fail = 1'b0;
    zeros = 0;
    n = 0;
    while (!adc_en && n < 200) begin zeros++; tick(1); n++; end
    chk("settle_zero_clks", zeros, 64);
    chk("settle_cnt", 32'(inter_fail_cnt), 1);
    chk("settle_back_run", 32'(state), S_RUN);

    // Backpressure: three words, consumer stalled for 10 clks.
    out_ready = 1'b0;
    push_word(1'b1, w0);
    push_word(1'b1, w);
    push_word(1'b1, w);
    tick(10);
    chk("bp_valid", 32'(out_valid), 1);
    chk_w("bp_head", out_data, w0);
    hs0 = hs_count;
    out_ready = 1'b1;
    n = 0;
    while (hs_count - hs0 < 3 && n < 40) begin tick(1); n++; end
    tick(5);
    chk("bp_handshakes", hs_count - hs0, 3);
    chk("bp_no_dup", 32'(out_valid), 0);

    // Drain with the consumer stalled; re-asserting enable must be ignored.
    out_ready = 1'b0;
    push_word(1'b1, w);
    push_word(1'b1, w);
    hs0 = hs_count;
    enable = 1'b0;
    tick(3);
    chk("drain_state", 32'(state), S_DRAIN);
    enable = 1'b1;
    tick(2);
    chk("drain_ignores_enable", 32'(state), S_DRAIN);
    enable = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (state != 3'(S_IDLE) && n < 50) begin tick(1); n++; end
    chk("drain_idle", 32'(state), S_IDLE);
    chk("drain_delivered", hs_count - hs0, 2);
    chk("drain_adc_off", 32'(adc_en), 0);

    // Permanent and intermittent fail in the same clk.
    do_reset();
    bring_up(start_tab[1]);
    oht_inter_fail = 1'b1;
    oht_perm_fail  = 1'b1;
    tick(1);
    oht_inter_fail = 1'b0;
    oht_perm_fail  = 1'b0;
    chk("both_state", 32'(state), S_FAULT);
    chk("both_cnt", 32'(inter_fail_cnt), 1);
    chk("both_fault", 32'(fault), 1);

    // Permanent fail while a word is held.
    do_reset();
    bring_up(start_tab[1]);
    mon_on = 1'b0;
    out_ready = 1'b0;
    push_word(1'b0, w);
    push_word(1'b0, w);
    n = 0;
    while (!out_valid && n < 20) begin tick(1); n++; end
    chk("pf_valid_before", 32'(out_valid), 1);
    oht_perm_fail = 1'b1;
    tick(1);
    oht_perm_fail = 1'b0;
    chk("pf_state", 32'(state), S_FAULT);
    chk("pf_valid", 32'(out_valid), 0);
    chk("pf_adc_en", 32'(adc_en), 0);
    chk("pf_fault", 32'(fault), 1);
    for (int i = 0; i < 6; i++) begin
      enable = ~enable;
      out_ready = 1'b1;
      tick(1);
      chk("pf_no_deque", 32'(oht_deque), 0);
    end
    chk("pf_sticky", 32'(state), S_FAULT);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("pf_rst");

    // Random traffic and backpressure in RUN against the scoreboard.
    do_reset();
    bring_up(start_tab[2]);
    hs0 = hs_count;
    pushed = 0;
    since = 0;
    gap_bad = 0;
    have = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      out_ready = 1'($urandom % 2);
      if ($urandom % 3 == 0) begin push_word(1'b1, w); pushed++; end
      tick(1);
      since++;
      if (adc_en) begin
        if (have && since != 3) gap_bad++;
        have = 1'b1;
        since = 0;
      end
    end
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < 200) begin tick(1); n++; end
    chk("rand_all_delivered", hs_count - hs0, pushed);
    chk("rand_exp_empty", exp_q.size(), 0);
    chk("rand_period_errs", gap_bad, 0);
    chk("rand_state", 32'(state), S_RUN);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("run_rst");

    chk("fifo_underflow", 32'(underflow), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
